// File: rtl/alu_selftest.sv
// alu_selftest: self-test sequencer wrapping an 8-bit ALU. Drives four fixed add
// vectors onto a/b/op, samples {carry,y} SETTLE edges after each load, counts
// passes/fails and reports overall status on led_status.
// Latency: done rises 4*SETTLE + 3*TICK_DIV edges after the start edge.
// Backpressure: none; start is only honoured in IDLE or DONE and ignored while busy.
//
// Ports:
//   CLK100MHZ  sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      level, begins a run from IDLE or DONE
//   a, b, op   registered ALU operands / opcode (op is always add)
//   y, carry   ALU result, sampled only on the compare edge
//   busy, done run in progress / run complete
//   pass_cnt, fail_cnt  vectors matched / mismatched (0..4)
//   led_status high when done and no vector failed
//
// Build option: define ALU_SELFTEST_LOOP_EN to make DONE auto-restart after
// TICK_DIV edges (start is still honoured in DONE).

module alu_selftest #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SETTLE   = 2
) (
    input  logic       CLK100MHZ,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [1:0] op,
    input  logic [7:0] y,
    input  logic       carry,
    output logic       busy,
    output logic       done,
    output logic [2:0] pass_cnt,
    output logic [2:0] fail_cnt,
    output logic       led_status
);

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);
    localparam logic [31:0] TICK_LAST   = 32'(TICK_DIV - 1);
    localparam logic [1:0]  OP_ADD      = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [7:0]  a_nxt, b_nxt;
    logic [1:0]  op_nxt;
    logic        busy_nxt, done_nxt, led_nxt;
    logic [2:0]  pass_nxt, fail_nxt;
    logic        begin_run;

    // Vector table: operands and expected {carry, y}.
    function automatic logic [7:0] vec_a(input logic [1:0] i);
        case (i)
            2'd0:    vec_a = 8'd3;
            2'd1:    vec_a = 8'd7;
            2'd2:    vec_a = 8'd15;
            default: vec_a = 8'd200;
        endcase
    endfunction

    function automatic logic [7:0] vec_b(input logic [1:0] i);
        case (i)
            2'd0:    vec_b = 8'd5;
            2'd1:    vec_b = 8'd8;
            2'd2:    vec_b = 8'd1;
            default: vec_b = 8'd100;
        endcase
    endfunction

    function automatic logic [8:0] vec_exp(input logic [1:0] i);
        case (i)
            2'd0:    vec_exp = {1'b0, 8'd8};
            2'd1:    vec_exp = {1'b0, 8'd15};
            2'd2:    vec_exp = {1'b0, 8'd16};
            default: vec_exp = {1'b1, 8'd44};
        endcase
    endfunction

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            cnt        <= 32'd0;
            a          <= 8'd0;
            b          <= 8'd0;
            op         <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_cnt   <= 3'd0;
            fail_cnt   <= 3'd0;
            led_status <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            a          <= a_nxt;
            b          <= b_nxt;
            op         <= op_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass_cnt   <= pass_nxt;
            fail_cnt   <= fail_nxt;
            led_status <= led_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        a_nxt     = a;
        b_nxt     = b;
        op_nxt    = op;
        busy_nxt  = busy;
        done_nxt  = done;
        pass_nxt  = pass_cnt;
        fail_nxt  = fail_cnt;
        begin_run = 1'b0;

        case (state)
            ST_IDLE: begin
                begin_run = start;
            end

            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    // y/carry are looked at only on this edge, so the ALU may
                    // glitch freely during the rest of the settle window.
                    if ({carry, y} == vec_exp(idx)) begin
                        pass_nxt = pass_cnt + 3'd1;
                    end else begin
                        fail_nxt = fail_cnt + 3'd1;
                    end
                    cnt_nxt = 32'd0;
                    if (idx == 2'd3) begin
                        state_nxt = ST_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end

            ST_WAIT: begin
                if (cnt == TICK_LAST) begin
                    idx_nxt   = idx + 2'd1;
                    a_nxt     = vec_a(idx + 2'd1);
                    b_nxt     = vec_b(idx + 2'd1);
                    op_nxt    = OP_ADD;
                    cnt_nxt   = 32'd0;
                    state_nxt = ST_SETTLE;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end

            ST_DONE: begin
`ifdef ALU_SELFTEST_LOOP_EN
                begin_run = start || (cnt == TICK_LAST);
                if (!begin_run) begin
                    cnt_nxt = cnt + 32'd1;
                end
`else
                begin_run = start;
`endif
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Starting a run is identical from IDLE and DONE: load vector 0 and
        // clear the tallies on the same edge that drops done.
        if (begin_run) begin
            idx_nxt   = 2'd0;
            cnt_nxt   = 32'd0;
            a_nxt     = vec_a(2'd0);
            b_nxt     = vec_b(2'd0);
            op_nxt    = OP_ADD;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
            pass_nxt  = 3'd0;
            fail_nxt  = 3'd0;
            state_nxt = ST_SETTLE;
        end

        led_nxt = done_nxt && (fail_nxt == 3'd0);
    end

endmodule

// File: tb/tb_alu_selftest.sv
// tb_alu_selftest: directed bench for alu_selftest with a behavioural adder
// model that can force carry low or emit garbage right after each load.
// Runs with TICK_DIV=4, SETTLE=2 so a full run takes 20 edges.

module tb_alu_selftest;

    localparam int TD     = 4;
    localparam int ST     = 2;
    localparam int PERIOD = ST + TD;          // edges between loads
    localparam int DONE_E = 4 * ST + 3 * TD;  // done edge relative to start

    logic       CLK100MHZ;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic [1:0] op;
    logic [7:0] y;
    logic       carry;
    logic       busy, done, led_status;
    logic [2:0] pass_cnt, fail_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // ALU model controls
    logic       force_c0 = 1'b0;
    logic       garbage  = 1'b0;
    int         age      = 0;
    logic [15:0] prev_ab = 16'd0;

    alu_selftest #(.TICK_DIV(TD), .SETTLE(ST)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .op         (op),
        .y          (y),
        .carry      (carry),
        .busy       (busy),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .led_status (led_status)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    // Age of the current operands in cycles, measured mid-cycle.
    always @(negedge CLK100MHZ) begin
        if ({a, b} != prev_ab) begin
            age     = 0;
            prev_ab = {a, b};
        end else begin
            age = age + 1;
        end
    end

    always @* begin
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (garbage && (age < ST - 1)) sum = ~sum;
        if (force_c0) sum[8] = 1'b0;
        {carry, y} = sum;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    // One full run from a start edge; start optionally held high afterwards.
    task automatic do_run(input string name, input int ep, input int ef, input bit hold);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check({name, " load0 a"}, 32'(a), 32'd3);
        check({name, " load0 b"}, 32'(b), 32'd5);
        check({name, " load0 op"}, 32'(op), 32'd0);
        check({name, " load0 busy"}, 32'(busy), 32'd1);
        check({name, " load0 done"}, 32'(done), 32'd0);
        check({name, " load0 pass"}, 32'(pass_cnt), 32'd0);
        for (int e = 1; e <= DONE_E; e++) begin
            tick();
            if (e == ST)
                check({name, " tally after v0"}, 32'(pass_cnt) + 32'(fail_cnt), 32'd1);
            if (e == PERIOD - 1)
                check({name, " v0 held a"}, 32'(a), 32'd3);
            if (e == PERIOD) begin
                check({name, " load1 a"}, 32'(a), 32'd7);
                check({name, " load1 b"}, 32'(b), 32'd8);
            end
            if (e == 2 * PERIOD) begin
                check({name, " load2 a"}, 32'(a), 32'd15);
                check({name, " load2 b"}, 32'(b), 32'd1);
            end
            if (e == 3 * PERIOD) begin
                check({name, " load3 a"}, 32'(a), 32'd200);
                check({name, " load3 b"}, 32'(b), 32'd100);
            end
            if (e == DONE_E - 1) begin
                check({name, " pre-done done"}, 32'(done), 32'd0);
                check({name, " pre-done busy"}, 32'(busy), 32'd1);
            end
        end
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " pass_cnt"}, 32'(pass_cnt), 32'(ep));
        check({name, " fail_cnt"}, 32'(fail_cnt), 32'(ef));
        check({name, " led"}, 32'(led_status), (ef == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " a"}, 32'(a), 32'd0);
        check({name, " b"}, 32'(b), 32'd0);
        check({name, " op"}, 32'(op), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " done"}, 32'(done), 32'd0);
        check({name, " pass"}, 32'(pass_cnt), 32'd0);
        check({name, " fail"}, 32'(fail_cnt), 32'd0);
        check({name, " led"}, 32'(led_status), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check("idle no start busy", 32'(busy), 32'd0);
        check("idle no start a", 32'(a), 32'd0);

        // Correct adder.
        do_run("clean", 4, 0, 1'b0);

        // Carry stuck low: only vector 3 should fail.
        force_c0 = 1'b1;
        do_run("carry0", 3, 1, 1'b0);
        force_c0 = 1'b0;

        // Garbage result right after each load must not be sampled.
        garbage = 1'b1;
        do_run("garbage", 4, 0, 1'b0);
        garbage = 1'b0;

        // start held high: one run, then restart on first DONE edge.
        do_run("hold", 4, 0, 1'b1);
        tick();
        check("hold restart done", 32'(done), 32'd0);
        check("hold restart busy", 32'(busy), 32'd1);
        check("hold restart pass", 32'(pass_cnt), 32'd0);
        check("hold restart fail", 32'(fail_cnt), 32'd0);
        check("hold restart a", 32'(a), 32'd3);
        check("hold restart led", 32'(led_status), 32'd0);
        start = 1'b0;
        repeat (DONE_E) tick();
        check("hold second done", 32'(done), 32'd1);
        check("hold second pass", 32'(pass_cnt), 32'd4);

        // Async reset in WAIT after vector 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (PERIOD + ST + 1) tick();
        check("midrun pass before reset", 32'(pass_cnt), 32'd2);
        check("midrun a before reset", 32'(a), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        tick();
        rst_n = 1'b1;
        tick();
        check("post reset idle busy", 32'(busy), 32'd0);
        do_run("after reset", 4, 0, 1'b0);

`ifdef ALU_SELFTEST_LOOP_EN
        repeat (TD - 1) tick();
        check("loop pre-restart done", 32'(done), 32'd1);
        tick();
        check("loop restart done", 32'(done), 32'd0);
        check("loop restart busy", 32'(busy), 32'd1);
        check("loop restart led", 32'(led_status), 32'd0);
        check("loop restart a", 32'(a), 32'd3);
        repeat (DONE_E - 1) tick();
        check("loop second pre-done", 32'(done), 32'd0);
        tick();
        check("loop second done", 32'(done), 32'd1);
        check("loop second pass", 32'(pass_cnt), 32'd4);
`else
        repeat (3 * TD) tick();
        check("hold in done", 32'(done), 32'd1);
        check("hold in done busy", 32'(busy), 32'd0);
        check("hold in done a", 32'(a), 32'd200);
        check("hold in done led", 32'(led_status), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_selftest.md
# alu_selftest

Self-test sequencer that wraps the board-level `alu8` instance. It drives a fixed table of four add vectors into the ALU operand inputs, waits for the result to settle, and compares `y`/`carry` against expected values. It tallies pass/fail counts and reports overall status on one LED. It replaces free-running divided-clock stimulus with a single-clock, clock-enable-paced FSM.

## Interface

Parameters:
- `TICK_DIV`, default 50_000_000: cycles spent in WAIT between vectors (≥1).
- `SETTLE`, default 2: cycles from operand load to result sample (≥1).

Ports:
- `CLK100MHZ`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level sampled in IDLE or DONE; begins a run.
- `a`, output, 8: ALU operand A (registered).
- `b`, output, 8: ALU operand B (registered).
- `op`, output, 2: ALU opcode (registered; always 2'b00 in this table).
- `y`, input, 8: ALU result.
- `carry`, input, 1: ALU carry out.
- `busy`, output, 1: run in progress.
- `done`, output, 1: run complete, results valid.
- `pass_cnt`, output, 3: vectors matched.
- `fail_cnt`, output, 3: vectors mismatched.
- `led_status`, output, 1: high only when `done` is high and `fail_cnt` is 0.

## Operation

Vector table, index 0..3, as (a, b) -> expected (y, carry):
- 0: (3, 5) -> (8, 0).
- 1: (7, 8) -> (15, 0).
- 2: (15, 1) -> (16, 0).
- 3: (200, 100) -> (44, 1).

FSM states: IDLE, SETTLE, WAIT, DONE.
- **IDLE**: if `start` is high, load vector 0 onto `a`/`b`/`op`, set `busy`, clear both counters, set idx=0, and go to SETTLE.
- **SETTLE**: count `SETTLE` edges. On the last one, compare `{carry,y}` with the expected value and increment `pass_cnt` or `fail_cnt`.
  - If idx==3, go to DONE: `busy`=0, `done`=1.
  - Otherwise go to WAIT.
- **WAIT**: count `TICK_DIV` edges. On the last one, increment idx, load that vector, and go to SETTLE.
- **DONE**: hold operands and counters. If `start` is high, restart exactly as from IDLE (counters cleared, `done`=0 on the same edge).

Rules:
- `start` is ignored while `busy`.
- Counters cannot exceed 4; the total `pass_cnt + fail_cnt` equals vectors checked so far.
- A mismatch in either `y` or `carry` counts as a fail.
- Operands change only on load edges and are stable through the entire SETTLE window.

Reset (asynchronous, any time including mid-run):
- State goes to IDLE.
- `a`, `b`, `op`, `busy`, `done`, `pass_cnt`, `fail_cnt`, `led_status` all go to 0.
- idx and internal counters go to 0.

## Timing

- Load edge L: operands valid after L.
- Compare at edge L+SETTLE; counter updates are visible after that edge.
- Next load occurs at edge L+SETTLE+TICK_DIV.
- Full run from the start edge S: `done` rises at edge S + 4·SETTLE + 3·TICK_DIV.
- `busy` falls and `done` rises on the same edge; they are never both high.
- `led_status` is registered and updates on the same edge as `done`.
- No combinational path from `y`/`carry` to any output.

## Configuration

- `ALU_SELFTEST_LOOP_EN` defined: DONE waits `TICK_DIV` edges and then auto-restarts as if `start` were high. `led_status` and `done` drop at the restart edge. `start` is still honoured in DONE.
- Not defined: DONE holds indefinitely until `start` or reset.

## Test plan

- Correct adder, `TICK_DIV`=4, `SETTLE`=2, `start` pulsed at edge 0 -> `done` at edge 20, `pass_cnt`=4, `fail_cnt`=0, `led_status`=1, operand sequence (3,5), (7,8), (15,1), (200,100).
- ALU model forcing `carry`=0 -> vector 3 fails; final `pass_cnt`=3, `fail_cnt`=1, `led_status`=0.
- `start` held high throughout the run -> exactly one run in progress. With the macro off, a new run begins on the first edge in DONE with `start` high: counters cleared and `done`=0.
- `rst_n` asserted asynchronously between edges during WAIT after vector 1 -> all outputs 0 immediately, state IDLE. After release, `start` gives a clean 4-vector run.
- `y` checked only at sample edges: the model outputs garbage for the first `SETTLE`-1 cycles after each load, then the correct value -> still 4 passes.
- `ALU_SELFTEST_LOOP_EN` defined, `start` pulsed once -> a second run starts `TICK_DIV` edges after the first `done`, and `done` again at edge 20 after that restart.
